counter_run_ctrl: RTL and testbench

Run/pause/clear sequencer for the free-running up-counter that feeds the seven-segment display path. Converts three raw push-button inputs into a 4-state control FSM. Divides clk down to a count rate and emits the single-cycle en and synchronous-clear strobes the counter consumes. Watches the counter value and stops, or optionally wraps, at a programmable terminal count.

---
 rtl/counter_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_counter_run_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: run/pause/clear sequencer for the display up-counter.
// Synchronises three raw push-buttons, edge-detects them into single presses,
// runs a 4-state FSM (IDLE/RUN/PAUSE/DONE), divides clk down to the count rate
// and issues one-cycle cnt_en / cnt_clr strobes to the counter.
//
// Optional build macro: COUNTER_RUN_CTRL_WRAP_EN
//   defined   -> terminal count issues cnt_clr and keeps running (wraps)
//   undefined -> terminal count stops in DONE
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high
//   btn_start  raw start button (async level)
//   btn_stop   raw stop/pause button (async level)
//   btn_clear  raw clear button (async level)
//   cnt_value  current counter value [N-1:0]
//   cnt_en     registered count-enable strobe
//   cnt_clr    registered one-cycle clear strobe
//   state      FSM state: IDLE=00 RUN=01 PAUSE=10 DONE=11
//   done       high while state==DONE
module counter_run_ctrl #(
  parameter int unsigned N     = 16,
  parameter int unsigned DIV   = 50000000,
  parameter int unsigned LIMIT = 9999
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_start,
  input  logic         btn_stop,
  input  logic         btn_clear,
  input  logic [N-1:0] cnt_value,
  output logic         cnt_en,
  output logic         cnt_clr,
  output logic [1:0]   state,
  output logic         done
);

  localparam int unsigned PW = $clog2(DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc;

  // Button vectors are ordered {clear, stop, start}
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;
  logic [2:0] press;

  logic press_start;
  logic press_stop;
  logic press_clear;
  logic tick;
  logic at_limit;

  assign btn_raw     = {btn_clear, btn_stop, btn_start};
  assign press       = sync2 & ~prev;
  assign press_start = press[0];
  assign press_stop  = press[1];
  assign press_clear = press[2];

  // Count-rate tick: last prescaler phase while running
  assign tick     = (state_q == RUN) && (presc == PW'(DIV - 1));
  assign at_limit = (cnt_value == N'(LIMIT));

  assign state = state_q;

  // Synchronisers, edge detect, FSM, prescaler and strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      state_q <= IDLE;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      done    <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      prev    <= sync2;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;

      // Clear outranks every other press and every tick
      if (press_clear) begin
        state_q <= IDLE;
        presc   <= '0;
        cnt_clr <= 1'b1;
        done    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            presc <= '0;
            if (press_start) begin
              state_q <= RUN;
            end
          end
          RUN: begin
            // Stop wins over a coincident tick; prescaler keeps its phase
            if (press_stop) begin
              state_q <= PAUSE;
            end else if (tick) begin
              presc <= '0;
              if (at_limit) begin
`ifdef COUNTER_RUN_CTRL_WRAP_EN
                cnt_clr <= 1'b1;
`else
                state_q <= DONE;
                done    <= 1'b1;
`endif
              end else begin
                cnt_en <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          PAUSE: begin
            if (press_start) begin
              state_q <= RUN;
            end
          end
          DONE: begin
            presc <= '0;
          end
          default: begin
            state_q <= IDLE;
            presc   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Testbench for counter_run_ctrl with DIV=4, LIMIT=3. Includes a model of the
// counter being driven, a cycle-level reference of the sequencer behaviour,
// a per-cycle compare and directed checks with literal expectations.
module tb_counter_run_ctrl;

  localparam int unsigned N     = 16;
  localparam int unsigned DIV   = 4;
  localparam int unsigned LIMIT = 3;

  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_STOP  = 3'b010;
  localparam logic [2:0] B_CLEAR = 3'b100;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         btn_start, btn_stop, btn_clear;
  logic [N-1:0] cnt_value;
  logic         cnt_en, cnt_clr;
  logic [1:0]   state;
  logic         done;

  int checks = 0;
  int errors = 0;

  counter_run_ctrl #(.N(N), .DIV(DIV), .LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_clear (btn_clear),
    .cnt_value (cnt_value),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .state     (state),
    .done      (done)
  );

  always #5 clk = ~clk;

  // The up-counter the sequencer drives
  always @(posedge clk or posedge reset) begin
    if (reset)        cnt_value <= '0;
    else if (cnt_clr) cnt_value <= '0;
    else if (cnt_en)  cnt_value <= cnt_value + N'(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a press is seen two edges after the first high sample of a
  // button that was low on the sample before; run time is tracked as the
  // number of RUN cycles since the last count step.
  int         m_mode;
  int         m_phase;
  bit         m_en, m_clr;
  bit [2:0]   smp0, smp1, smp2;
  bit [2:0]   pr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_phase = 0; m_en = 0; m_clr = 0;
      smp0 = '0; smp1 = '0; smp2 = '0;
    end else begin
      pr   = smp1 & ~smp2;
      smp2 = smp1;
      smp1 = smp0;
      smp0 = {btn_clear, btn_stop, btn_start};
      m_en = 0; m_clr = 0;
      if (pr[2]) begin
        m_mode = M_IDLE; m_phase = 0; m_clr = 1;
      end else if (m_mode == M_RUN) begin
        if (pr[1]) begin
          m_mode = M_PAUSE;
        end else if (m_phase == int'(DIV) - 1) begin
          m_phase = 0;
          if (int'(cnt_value) == int'(LIMIT)) begin
`ifdef COUNTER_RUN_CTRL_WRAP_EN
            m_clr = 1;
`else
            m_mode = M_DONE;
`endif
          end else begin
            m_en = 1;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end else if (m_mode == M_IDLE && pr[0]) begin
        m_mode = M_RUN; m_phase = 0;
      end else if (m_mode == M_PAUSE && pr[0]) begin
        m_mode = M_RUN;
      end
      if (m_mode == M_IDLE || m_mode == M_DONE) m_phase = 0;
    end
  end

  // Per-cycle compare plus strobe / RUN-entry tallies
  int   en_count  = 0;
  int   run_entry = 0;
  logic [1:0] prev_st = 2'b00;

  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_state",   32'(state),   32'(m_mode));
      check("cyc_cnt_en",  32'(cnt_en),  32'(m_en));
      check("cyc_cnt_clr", 32'(cnt_clr), 32'(m_clr));
      check("cyc_done",    32'(done),    32'(m_mode == M_DONE));
      if (cnt_en) en_count++;
      if (state == 2'b01 && prev_st != 2'b01) run_entry++;
      prev_st = state;
    end else begin
      prev_st = 2'b00;
    end
  end

  // Hold the given buttons across one sampling edge
  task automatic press(input logic [2:0] m);
    {btn_clear, btn_stop, btn_start} = m;
    @(negedge clk);
    {btn_clear, btn_stop, btn_start} = 3'b000;
  endtask

  task automatic wait_en(input int budget);
    int n;
    n = 0;
    while (cnt_en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_en_timeout", 32'(cnt_en), 32'd1);
  endtask

  int snap;

  initial begin
    reset = 1'b1;
    {btn_clear, btn_stop, btn_start} = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_en",    32'(cnt_en), 32'd0);
    check("rst_clr",   32'(cnt_clr), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Start, latency, count spacing, terminal
    snap = en_count;
    press(B_START);
    @(negedge clk); check("start_lat", 32'(state), 32'd0);
    @(negedge clk); check("start_run", 32'(state), 32'd1);
    repeat (3) @(negedge clk); check("pre_tick_en", 32'(cnt_en), 32'd0);
    @(negedge clk); check("first_tick_en", 32'(cnt_en), 32'd1);
    check("first_tick_val", 32'(cnt_value), 32'd0);
`ifndef COUNTER_RUN_CTRL_WRAP_EN
    repeat (11) @(negedge clk);
    check("pre_term_state", 32'(state), 32'd1);
    check("pre_term_val", 32'(cnt_value), 32'd3);
    @(negedge clk);
    check("term_state", 32'(state), 32'd3);
    check("term_done", 32'(done), 32'd1);
    check("term_no_en", 32'(cnt_en), 32'd0);
    repeat (8) @(negedge clk);
    #1 check("run_en_total", 32'(en_count - snap), 32'd3);

    // DONE ignores start and stop; clear leaves it
    press(B_START); repeat (3) @(negedge clk);
    check("done_start_ign", 32'(state), 32'd3);
    press(B_STOP);  repeat (3) @(negedge clk);
    check("done_stop_ign", 32'(state), 32'd3);
`else
    @(negedge clk); check("wrap_v1", 32'(cnt_value), 32'd1);
    repeat (4) @(negedge clk); check("wrap_v2", 32'(cnt_value), 32'd2);
    repeat (4) @(negedge clk); check("wrap_v3", 32'(cnt_value), 32'd3);
    repeat (3) @(negedge clk);
    check("wrap_clr", 32'(cnt_clr), 32'd1);
    check("wrap_state", 32'(state), 32'd1);
    check("wrap_done", 32'(done), 32'd0);
    @(negedge clk); check("wrap_v0", 32'(cnt_value), 32'd0);
    repeat (4) @(negedge clk); check("wrap_v1b", 32'(cnt_value), 32'd1);
`endif
    press(B_CLEAR);
    @(negedge clk);
    @(negedge clk);
    check("clr_state", 32'(state), 32'd0);
    check("clr_pulse", 32'(cnt_clr), 32'd1);
    check("clr_done", 32'(done), 32'd0);
    @(negedge clk);
    check("clr_pulse_end", 32'(cnt_clr), 32'd0);
    check("clr_val", 32'(cnt_value), 32'd0);

    // Pause six cycles into RUN, then resume with phase preserved
    press(B_START);
    repeat (2) @(negedge clk);
    check("p_run", 32'(state), 32'd1);
    repeat (3) @(negedge clk);
    press(B_STOP);
    check("p_tick_before", 32'(cnt_en), 32'd1);
    repeat (2) @(negedge clk);
    check("p_paused", 32'(state), 32'd2);
    #1 snap = en_count;
    repeat (10) @(negedge clk);
    #1 check("p_no_en", 32'(en_count - snap), 32'd0);
    check("p_still", 32'(state), 32'd2);
    press(B_START);
    repeat (2) @(negedge clk);
    check("resume_state", 32'(state), 32'd1);
    check("resume_en0", 32'(cnt_en), 32'd0);
    repeat (2) @(negedge clk); check("resume_en1", 32'(cnt_en), 32'd0);
    @(negedge clk); check("resume_tick", 32'(cnt_en), 32'd1);
    repeat (3) @(negedge clk); check("resume_gap", 32'(cnt_en), 32'd0);
    @(negedge clk); check("resume_tick2", 32'(cnt_en), 32'd1);

    // Clear and stop on the same edge
    press(B_CLEAR | B_STOP);
    repeat (2) @(negedge clk);
    check("cs_state", 32'(state), 32'd0);
    check("cs_clr", 32'(cnt_clr), 32'd1);
    check("cs_en", 32'(cnt_en), 32'd0);
    @(negedge clk);
    check("cs_clr_end", 32'(cnt_clr), 32'd0);
    check("cs_val", 32'(cnt_value), 32'd0);

    // Start held for 20 cycles gives a single entry into RUN
    #1 snap = run_entry;
    btn_start = 1'b1;
    repeat (20) @(negedge clk);
    btn_start = 1'b0;
    #1 check("hold_entries", 32'(run_entry - snap), 32'd1);

    // Asynchronous reset in the middle of a count strobe
    press(B_CLEAR);
    repeat (3) @(negedge clk);
    press(B_START);
    wait_en(12);
    #1 reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_en", 32'(cnt_en), 32'd0);
    check("arst_clr", 32'(cnt_clr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_state", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
